hand_paddle_tracker: RTL and testbench
======================================

// Module: hand_paddle_tracker
// PURPOSE
//  Downstream of hand recognition. Turns per-cycle hand_detected/hand_x/hand_y into a
//  smoothed, clamped paddle Y position, once per video frame. A confidence FSM
//  (acquire/track/hold/idle) rejects detection glitches. Output feeds the pong paddle renderer.
// PARAMETERS
//  SCREEN_H      480  visible lines
//  PADDLE_H      80   paddle height in lines
//  SMOOTH_SHIFT  2    filter: step = (target - paddle_y) >>> SMOOTH_SHIFT
//  MAX_STEP      32   max |step| per frame, in lines
//  ACQ_FRAMES    3    consecutive detected frames to enter TRACK
//  LOST_FRAMES   8    consecutive undetected frames in HOLD before IDLE
//  X_GATE_MAX    320  hand_x upper bound (exclusive) when X_GATE_EN is defined
// PORTS
//  VGA_CLK       in   1   pixel clock; the block's only clock
//  RST_N         in   1   asynchronous, active-low reset
//  frame_tick    in   1   1-cycle pulse marking the end of a frame
//  hand_detected in   1   hand present this cycle
//  hand_x        in   11  hand centre X, qualified by hand_detected
//  hand_y        in   11  hand centre Y, qualified by hand_detected
//  paddle_y      out  11  top line of paddle, always in [0, SCREEN_H-PADDLE_H]
//  paddle_valid  out  1   1 when state is TRACK or HOLD
//  track_state   out  2   0=IDLE 1=ACQUIRE 2=TRACK 3=HOLD
// BEHAVIOUR
//  Reset: paddle_y=CENTER=(SCREEN_H-PADDLE_H)/2 (200). paddle_valid=0, track_state=IDLE.
//   All counters, flags and the sample register are cleared.
//  Per-frame sampling:
//   - A sticky seen flag is set on any cycle with an accepted detection.
//   - sample_y captures hand_y on every accepted detection; the last one in the frame wins.
//   - A detection in the same cycle as frame_tick counts for the closing frame.
//   - seen is cleared on frame_tick; the next frame starts clear.
//  Target: t = hand_y - PADDLE_H/2, saturating at 0, clamped to at most SCREEN_H-PADDLE_H.
//  Filter, evaluated on frame_tick:
//   - d = target - paddle_y, as 12-bit signed.
//   - step = d >>> SMOOTH_SHIFT. If d!=0 and step==0, step = sign(d) (guarantees convergence).
//   - |step| is clamped to MAX_STEP, and the result is clamped to the legal range.
//  Latency: paddle_y, state and paddle_valid update on the cycle after frame_tick
//   (registered). Between ticks they are stable.
//  FSM, evaluated only on frame_tick (s = seen):
//   - IDLE:    s -> ACQUIRE with acq_cnt=1. Else stay. Filter toward CENTER.
//   - ACQUIRE: s -> acq_cnt+1, and enter TRACK when the count reaches ACQ_FRAMES.
//              !s -> IDLE, acq_cnt=0. paddle_y holds.
//   - TRACK:   s -> filter toward target(sample_y). !s -> HOLD with lost_cnt=1, paddle_y holds.
//   - HOLD:    s -> TRACK, lost_cnt=0, and filter this tick.
//              !s -> lost_cnt+1, and enter IDLE when the count reaches LOST_FRAMES.
//              paddle_y frozen while in HOLD.
//  ACQ_FRAMES=1 goes IDLE->ACQUIRE->TRACK on consecutive ticks; the counters never overflow.
//  Reset asserted mid-frame discards the partial frame's samples.
// CONFIGURATION
//  X_GATE_EN defined: a detection is accepted only if hand_x < X_GATE_MAX (player-side half).
//   Other detections are ignored entirely.
//  X_GATE_EN undefined: every detection is accepted, and hand_x is unused.
// TESTING
//  Defaults throughout.
//  1 Reset, no detections for 5 ticks -> paddle_y=200, paddle_valid=0, track_state=0.
//  2 hand_y=300 in 3 frames -> TRACK after the 3rd tick, paddle_y=200.
//    4th frame: target 260, d=60, step 15 -> paddle_y=215.
//  3 TRACK, paddle_y=200, hand_y=470 -> target 400, d=200, step 50 clamped to 32 -> 232.
//    hand_y=5 -> target 0, and paddle_y decreases monotonically to 0, never below.
//  4 Detect 2 frames, then a miss -> IDLE, acq_cnt=0. 3 more detected frames -> TRACK.
//  5 TRACK, 8 frames with no detection -> HOLD with paddle_y frozen, then IDLE with valid=0.
//    After that paddle_y eases back to 200.
//    Re-detect during HOLD at frame 4 -> TRACK with no re-acquire.
//  6 Detection only in the frame_tick cycle -> counted for that frame.
//    X_GATE_EN with hand_x=400 -> ignored, state stays IDLE.
//    RST_N pulsed low in TRACK -> outputs return to reset values immediately.

Source files
------------

// File: rtl/hand_paddle_tracker.sv
// hand_paddle_tracker
//   Turns per-cycle hand detections into a smoothed, clamped paddle Y position.
//   The position updates once per video frame. A confidence FSM
//   (IDLE/ACQUIRE/TRACK/HOLD) rejects detection glitches before the paddle moves.
//
// Optional feature macro: X_GATE_EN
//   When defined, a detection is accepted only if hand_x < X_GATE_MAX.
//   When undefined, every detection is accepted and hand_x is ignored.
//
// Ports
//   VGA_CLK       in   1   pixel clock, the only clock
//   RST_N         in   1   asynchronous active-low reset
//   frame_tick    in   1   one-cycle pulse at the end of each frame
//   hand_detected in   1   hand present this cycle
//   hand_x        in  11   hand centre X (qualified by hand_detected)
//   hand_y        in  11   hand centre Y (qualified by hand_detected)
//   paddle_y      out 11   paddle top line, always within [0, SCREEN_H-PADDLE_H]
//   paddle_valid  out  1   high in TRACK or HOLD
//   track_state   out  2   0=IDLE 1=ACQUIRE 2=TRACK 3=HOLD
module hand_paddle_tracker #(
  parameter int unsigned SCREEN_H     = 480,
  parameter int unsigned PADDLE_H     = 80,
  parameter int unsigned SMOOTH_SHIFT = 2,
  parameter int unsigned MAX_STEP     = 32,
  parameter int unsigned ACQ_FRAMES   = 3,
  parameter int unsigned LOST_FRAMES  = 8,
  parameter int unsigned X_GATE_MAX   = 320
) (
  input  logic        VGA_CLK,
  input  logic        RST_N,
  input  logic        frame_tick,
  input  logic        hand_detected,
  input  logic [10:0] hand_x,
  input  logic [10:0] hand_y,
  output logic [10:0] paddle_y,
  output logic        paddle_valid,
  output logic [1:0]  track_state
);

  localparam logic [10:0]        PMAX   = 11'(SCREEN_H - PADDLE_H);
  localparam logic [10:0]        CENTER = 11'((SCREEN_H - PADDLE_H) / 2);
  localparam logic [10:0]        HALF   = 11'(PADDLE_H / 2);
  localparam logic signed [11:0] MAXS   = 12'(MAX_STEP);
  localparam logic [7:0]         ACQ_N  = 8'(ACQ_FRAMES);
  localparam logic [7:0]         LOST_N = 8'(LOST_FRAMES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    TRACK   = 2'd2,
    HOLD    = 2'd3
  } state_t;

  state_t      state_q;
  logic [10:0] py_q;
  logic        valid_q;
  logic        seen_q;
  logic [10:0] sample_q;
  logic [7:0]  acq_q;
  logic [7:0]  lost_q;

  logic        accept;
  logic        seen_now;
  logic [10:0] sample_now;
  logic [10:0] target;

`ifdef X_GATE_EN
  assign accept = hand_detected && (hand_x < 11'(X_GATE_MAX));
`else
  logic unused_x;
  assign unused_x = ^{hand_x, 11'(X_GATE_MAX)};
  assign accept   = hand_detected;
`endif

  // A detection coincident with frame_tick belongs to the frame being closed,
  // so the tick-time view merges this cycle's detection with the sticky state.
  assign seen_now   = seen_q | accept;
  assign sample_now = accept ? hand_y : sample_q;

  always_comb begin
    target = '0;
    if (sample_now > HALF) target = sample_now - HALF;
    if (target > PMAX)     target = PMAX;
  end

  // One filter step from cur toward tgt. Arithmetic shift floors, so only a
  // small positive error can round to zero; it is forced to +1 to converge.
  function automatic logic [10:0] filt(input logic [10:0] cur, input logic [10:0] tgt);
    logic signed [11:0] d;
    logic signed [11:0] st;
    logic signed [12:0] r;
    d  = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    st = d >>> SMOOTH_SHIFT;
    if (d != '0 && st == '0) st = d[11] ? -12'sd1 : 12'sd1;
    if (st > MAXS)       st = MAXS;
    else if (st < -MAXS) st = -MAXS;
    r = $signed({2'b00, cur}) + $signed({st[11], st});
    if (r[12])                     return '0;
    else if (r[11:0] > {1'b0, PMAX}) return PMAX;
    else                           return r[10:0];
  endfunction

  always_ff @(posedge VGA_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      py_q     <= CENTER;
      valid_q  <= 1'b0;
      seen_q   <= 1'b0;
      sample_q <= '0;
      acq_q    <= '0;
      lost_q   <= '0;
    end else begin
      if (accept) sample_q <= hand_y;
      seen_q <= frame_tick ? 1'b0 : seen_now;
      if (frame_tick) begin
        unique case (state_q)
          IDLE: begin
            py_q <= filt(py_q, CENTER);
            if (seen_now) begin
              state_q <= ACQUIRE;
              acq_q   <= 8'd1;
            end
          end
          ACQUIRE: begin
            if (seen_now) begin
              if (acq_q + 8'd1 >= ACQ_N) begin
                state_q <= TRACK;
                acq_q   <= '0;
                valid_q <= 1'b1;
              end else begin
                acq_q <= acq_q + 8'd1;
              end
            end else begin
              state_q <= IDLE;
              acq_q   <= '0;
            end
          end
          TRACK: begin
            if (seen_now) begin
              py_q <= filt(py_q, target);
            end else begin
              state_q <= HOLD;
              lost_q  <= 8'd1;
            end
          end
          HOLD: begin
            if (seen_now) begin
              state_q <= TRACK;
              lost_q  <= '0;
              py_q    <= filt(py_q, target);
            end else if (lost_q + 8'd1 >= LOST_N) begin
              state_q <= IDLE;
              lost_q  <= '0;
              valid_q <= 1'b0;
            end else begin
              lost_q <= lost_q + 8'd1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign paddle_y     = py_q;
  assign paddle_valid = valid_q;
  assign track_state  = state_q;

endmodule

// File: tb/tb_hand_paddle_tracker.sv
module tb_hand_paddle_tracker;

  logic        VGA_CLK = 1'b0;
  logic        RST_N;
  logic        frame_tick;
  logic        hand_detected;
  logic [10:0] hand_x;
  logic [10:0] hand_y;
  logic [10:0] paddle_y;
  logic        paddle_valid;
  logic [1:0]  track_state;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int py;
    int valid;
    int st;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  int m_py, m_st, m_acq, m_lost;

  hand_paddle_tracker dut (
    .VGA_CLK      (VGA_CLK),
    .RST_N        (RST_N),
    .frame_tick   (frame_tick),
    .hand_detected(hand_detected),
    .hand_x       (hand_x),
    .hand_y       (hand_y),
    .paddle_y     (paddle_y),
    .paddle_valid (paddle_valid),
    .track_state  (track_state)
  );

  always #5 VGA_CLK = ~VGA_CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  // Reference filter: floor division written with integers.
  function automatic int m_filter(int cur, int t);
    int d, s, r;
    d = t - cur;
    s = (d >= 0) ? d / 4 : -((-d + 3) / 4);
    if (d != 0 && s == 0) s = (d > 0) ? 1 : -1;
    if (s > 32)  s = 32;
    if (s < -32) s = -32;
    r = cur + s;
    if (r < 0)   r = 0;
    if (r > 400) r = 400;
    return r;
  endfunction

  task automatic model_tick(input bit s, input int y);
    int t;
    t = y - 40;
    if (t < 0)   t = 0;
    if (t > 400) t = 400;
    case (m_st)
      0: begin
        m_py = m_filter(m_py, 200);
        if (s) begin m_st = 1; m_acq = 1; end
      end
      1: begin
        if (s) begin
          m_acq++;
          if (m_acq >= 3) begin m_st = 2; m_acq = 0; end
        end else begin
          m_st = 0; m_acq = 0;
        end
      end
      2: begin
        if (s) m_py = m_filter(m_py, t);
        else begin m_st = 3; m_lost = 1; end
      end
      default: begin
        if (s) begin m_st = 2; m_lost = 0; m_py = m_filter(m_py, t); end
        else begin
          m_lost++;
          if (m_lost >= 8) begin m_st = 0; m_lost = 0; end
        end
      end
    endcase
    sb.push_back('{m_py, int'(m_st == 2 || m_st == 3), m_st});
  endtask

  task automatic do_reset();
    @(negedge VGA_CLK);
    RST_N = 1'b0; frame_tick = 1'b0; hand_detected = 1'b0; hand_x = '0; hand_y = '0;
    m_py = 200; m_st = 0; m_acq = 0; m_lost = 0;
    sb.delete();
    repeat (2) @(negedge VGA_CLK);
    RST_N = 1'b1;
  endtask

  // One frame: detection (if any) mid-frame or only on the tick cycle; the
  // expected result is queued as the tick is driven.
  task automatic run_frame(input bit det, input int y, input int x, input bit tick_only);
    bit acc;
    for (int c = 0; c < 3; c++) begin
      @(negedge VGA_CLK);
      frame_tick = 1'b0;
      hand_detected = det && !tick_only && (c == 1);
      hand_x = 11'(x); hand_y = 11'(y);
    end
    @(negedge VGA_CLK);
    frame_tick = 1'b1;
    hand_detected = det && tick_only;
    acc = det;
`ifdef X_GATE_EN
    if (x >= 320) acc = 1'b0;
`endif
    model_tick(acc, y);
    @(posedge VGA_CLK);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_chk++;
    if (paddle_y !== 11'd200 || paddle_valid !== 1'b0 || track_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_values: got y=%0d v=%0b s=%0d want y=200 v=0 s=0", paddle_y, paddle_valid, track_state);
    end
    for (int i = 0; i < 5; i++) begin
      run_frame(1'b0, 0, 0, 1'b0);
      e = sb.pop_front(); n_chk++;
      if (paddle_y !== 11'(e.py) || paddle_valid !== 1'(e.valid) || track_state !== 2'(e.st)) begin
        n_fail++;
        $display("FAIL reset_idle_frame: got y=%0d v=%0b s=%0d want y=%0d v=%0d s=%0d", paddle_y, paddle_valid, track_state, e.py, e.valid, e.st);
      end
    end
    n_chk++;
    if (paddle_y !== 11'd200 || track_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_after_5: got y=%0d s=%0d want y=200 s=0", paddle_y, track_state);
    end
  endtask

  task automatic test_acquire_track();
    for (int i = 0; i < 4; i++) begin
      run_frame(1'b1, 300, 100, 1'b0);
      e = sb.pop_front(); n_chk++;
      if (paddle_y !== 11'(e.py) || paddle_valid !== 1'(e.valid) || track_state !== 2'(e.st)) begin
        n_fail++;
        $display("FAIL acq_frame%0d: got y=%0d v=%0b s=%0d want y=%0d v=%0d s=%0d", i, paddle_y, paddle_valid, track_state, e.py, e.valid, e.st);
      end
      if (i == 2) begin
        n_chk++;
        if (track_state !== 2'd2 || paddle_y !== 11'd200 || paddle_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL acq_enter_track: got y=%0d v=%0b s=%0d want y=200 v=1 s=2", paddle_y, paddle_valid, track_state);
        end
      end
    end
    n_chk++;
    if (paddle_y !== 11'd215) begin
      n_fail++;
      $display("FAIL track_first_step: got %0d want 215", paddle_y);
    end
  endtask

  task automatic test_clamp();
    int prev;
    for (int i = 0; i < 30 && m_py != 200; i++) begin
      run_frame(1'b1, 240, 0, 1'b0);
      e = sb.pop_front(); n_chk++;
      if (paddle_y !== 11'(e.py) || track_state !== 2'(e.st)) begin
        n_fail++;
        $display("FAIL clamp_settle: got y=%0d s=%0d want y=%0d s=%0d", paddle_y, track_state, e.py, e.st);
      end
    end
    n_chk++;
    if (paddle_y !== 11'd200) begin
      n_fail++;
      $display("FAIL clamp_settled: got %0d want 200", paddle_y);
    end
    run_frame(1'b1, 470, 0, 1'b0);
    void'(sb.pop_front());
    n_chk++;
    if (paddle_y !== 11'd232) begin
      n_fail++;
      $display("FAIL clamp_max_step: got %0d want 232", paddle_y);
    end
    prev = 232;
    for (int i = 0; i < 30; i++) begin
      run_frame(1'b1, 5, 0, 1'b0);
      e = sb.pop_front(); n_chk++;
      if (paddle_y !== 11'(e.py) || int'(paddle_y) > prev) begin
        n_fail++;
        $display("FAIL clamp_descend: got %0d want %0d (prev %0d)", paddle_y, e.py, prev);
      end
      prev = int'(paddle_y);
    end
    n_chk++;
    if (paddle_y !== 11'd0) begin
      n_fail++;
      $display("FAIL clamp_floor: got %0d want 0", paddle_y);
    end
  endtask

  task automatic test_glitch_reject();
    bit det;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      det = (i != 2);
      run_frame(det, 300, 0, 1'b0);
      e = sb.pop_front(); n_chk++;
      if (paddle_y !== 11'(e.py) || paddle_valid !== 1'(e.valid) || track_state !== 2'(e.st)) begin
        n_fail++;
        $display("FAIL glitch_frame%0d: got y=%0d v=%0b s=%0d want y=%0d v=%0d s=%0d", i, paddle_y, paddle_valid, track_state, e.py, e.valid, e.st);
      end
      if (i == 2) begin
        n_chk++;
        if (track_state !== 2'd0) begin
          n_fail++;
          $display("FAIL glitch_to_idle: got %0d want 0", track_state);
        end
      end
    end
    n_chk++;
    if (track_state !== 2'd2) begin
      n_fail++;
      $display("FAIL glitch_reacquire: got %0d want 2", track_state);
    end
  endtask

  task automatic test_hold_lost();
    int frozen;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      run_frame(1'b1, 470, 0, 1'b0);
      void'(sb.pop_front());
    end
    frozen = int'(paddle_y);
    n_chk++;
    if (paddle_y !== 11'd264) begin
      n_fail++;
      $display("FAIL hold_setup: got %0d want 264", paddle_y);
    end
    for (int i = 0; i < 8; i++) begin
      run_frame(1'b0, 0, 0, 1'b0);
      e = sb.pop_front(); n_chk++;
      if (paddle_y !== 11'(e.py) || paddle_valid !== 1'(e.valid) || track_state !== 2'(e.st)) begin
        n_fail++;
        $display("FAIL hold_frame%0d: got y=%0d v=%0b s=%0d want y=%0d v=%0d s=%0d", i, paddle_y, paddle_valid, track_state, e.py, e.valid, e.st);
      end
      n_chk++;
      if (i < 7 && (track_state !== 2'd3 || int'(paddle_y) != frozen || paddle_valid !== 1'b1)) begin
        n_fail++;
        $display("FAIL hold_frozen%0d: got y=%0d s=%0d want y=%0d s=3", i, paddle_y, track_state, frozen);
      end else if (i == 7 && (track_state !== 2'd0 || paddle_valid !== 1'b0)) begin
        n_fail++;
        $display("FAIL hold_to_idle: got s=%0d v=%0b want s=0 v=0", track_state, paddle_valid);
      end
    end
    for (int i = 0; i < 30; i++) begin
      run_frame(1'b0, 0, 0, 1'b0);
      e = sb.pop_front(); n_chk++;
      if (paddle_y !== 11'(e.py) || track_state !== 2'(e.st)) begin
        n_fail++;
        $display("FAIL ease_frame%0d: got y=%0d s=%0d want y=%0d s=%0d", i, paddle_y, track_state, e.py, e.st);
      end
    end
    n_chk++;
    if (paddle_y !== 11'd200) begin
      n_fail++;
      $display("FAIL ease_center: got %0d want 200", paddle_y);
    end
    for (int i = 0; i < 7; i++) begin
      run_frame(i < 3 || i == 6, 300, 0, 1'b0);
      e = sb.pop_front(); n_chk++;
      if (paddle_y !== 11'(e.py) || paddle_valid !== 1'(e.valid) || track_state !== 2'(e.st)) begin
        n_fail++;
        $display("FAIL redetect_frame%0d: got y=%0d v=%0b s=%0d want y=%0d v=%0d s=%0d", i, paddle_y, paddle_valid, track_state, e.py, e.valid, e.st);
      end
    end
    n_chk++;
    if (track_state !== 2'd2 || paddle_y !== 11'd215) begin
      n_fail++;
      $display("FAIL redetect_track: got s=%0d y=%0d want s=2 y=215", track_state, paddle_y);
    end
  endtask

  task automatic test_edge_cases();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      run_frame(1'b1, 300, 0, 1'b1);
      e = sb.pop_front(); n_chk++;
      if (paddle_y !== 11'(e.py) || track_state !== 2'(e.st)) begin
        n_fail++;
        $display("FAIL tick_only_frame%0d: got y=%0d s=%0d want y=%0d s=%0d", i, paddle_y, track_state, e.py, e.st);
      end
    end
    n_chk++;
    if (track_state !== 2'd2) begin
      n_fail++;
      $display("FAIL tick_only_track: got %0d want 2", track_state);
    end

    do_reset();
    run_frame(1'b1, 300, 400, 1'b0);
    e = sb.pop_front(); n_chk++;
`ifdef X_GATE_EN
    if (track_state !== 2'd0 || 2'(e.st) !== 2'd0) begin
`else
    if (track_state !== 2'd1 || 2'(e.st) !== 2'd1) begin
`endif
      n_fail++;
      $display("FAIL x_gate: got s=%0d model s=%0d", track_state, e.st);
    end

    do_reset();
    for (int i = 0; i < 4; i++) begin
      run_frame(1'b1, 470, 0, 1'b0);
      void'(sb.pop_front());
    end
    n_chk++;
    if (track_state !== 2'd2 || paddle_y !== 11'd232) begin
      n_fail++;
      $display("FAIL rst_setup: got s=%0d y=%0d want s=2 y=232", track_state, paddle_y);
    end
    @(negedge VGA_CLK);
    frame_tick = 1'b0; hand_detected = 1'b1; hand_y = 11'd300;
    @(negedge VGA_CLK);
    hand_detected = 1'b0;
    #2 RST_N = 1'b0;
    #1;
    n_chk++;
    if (paddle_y !== 11'd200 || paddle_valid !== 1'b0 || track_state !== 2'd0) begin
      n_fail++;
      $display("FAIL async_reset: got y=%0d v=%0b s=%0d want y=200 v=0 s=0", paddle_y, paddle_valid, track_state);
    end
    m_py = 200; m_st = 0; m_acq = 0; m_lost = 0;
    sb.delete();
    @(negedge VGA_CLK);
    @(negedge VGA_CLK);
    RST_N = 1'b1;
    run_frame(1'b0, 0, 0, 1'b0);
    e = sb.pop_front(); n_chk++;
    if (paddle_y !== 11'(e.py) || track_state !== 2'(e.st) || track_state !== 2'd0) begin
      n_fail++;
      $display("FAIL partial_discard: got y=%0d s=%0d want y=%0d s=0", paddle_y, track_state, e.py);
    end
  endtask

  initial begin
    RST_N = 1'b0; frame_tick = 1'b0; hand_detected = 1'b0; hand_x = '0; hand_y = '0;
    test_reset();
    test_acquire_track();
    test_clamp();
    test_glitch_reject();
    test_hold_lost();
    test_edge_cases();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
